// File: rtl/branch_predictor_pkg.sv
// Shared constants and helpers for the branch predictor: opcodes, counter
// encodings, BHT reset value, immediate extraction, saturating update.
package branch_predictor_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  localparam logic [1:0] BHT_RST = WEAK_NT;

  typedef struct packed {
    logic        valid;
    logic        is_jump;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  function automatic logic [31:0] j_imm(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic t);
    if (t) return (c == STRONG_T)  ? c : c + 2'd1;
    else   return (c == STRONG_NT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Query / commit-update / prediction bundle between IF, ROB and predictor.
// slave = predictor side, master = IF/ROB side.
interface branch_predictor_if;
  logic        query_valid;
  logic [31:0] query_pc;
  logic [31:0] query_instr;
  logic        update_valid;
  logic        update_taken;
  logic [31:0] update_pc;
  logic        jump_wrong;
  logic        pred_valid;
  logic        pred_is_jump;
  logic        pred_taken;
  logic [31:0] pred_target;

  modport slave (
    input  query_valid, query_pc, query_instr,
    input  update_valid, update_taken, update_pc, jump_wrong,
    output pred_valid, pred_is_jump, pred_taken, pred_target
  );

  modport master (
    output query_valid, query_pc, query_instr,
    output update_valid, update_taken, update_pc, jump_wrong,
    input  pred_valid, pred_is_jump, pred_taken, pred_target
  );
endinterface

// File: rtl/branch_predictor_bht_table.sv
// 2^IDX_W x 2-bit saturating counter table. Async read, sync update,
// async active-low reset to weakly not-taken. Reads see pre-update state.
module bht_table
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0][1:0] ctr_q, ctr_d;

  assign rd_ctr = ctr_q[rd_idx];

  // Saturating update of the single addressed entry
  always_comb begin
    ctr_d = ctr_q;
    if (we) ctr_d[wr_idx] = ctr_sat(ctr_q[wr_idx], wr_taken);
  end

  // Counter storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ctr_q <= {DEPTH{BHT_RST}};
    else      ctr_q <= ctr_d;
  end
endmodule

// File: rtl/branch_predictor.sv
// Branch predictor: bimodal BHT (gshare when BP_GSHARE_EN is defined),
// JAL/B-type decode, target adder, one-cycle registered prediction.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W  = 8,
  parameter int HIST_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  branch_predictor_if.slave bp
);
  logic [IDX_W-1:0] q_idx, u_idx;
  logic [1:0]       q_ctr;
  logic             upd_en;
  pred_t            pred_q, pred_d;
  pred_t            dec;

  assign upd_en = bp.update_valid && rdy;

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr_q, ghr_d;

  // Retired history: shift in each committed outcome, never repaired
  always_comb begin
    ghr_d = ghr_q;
    if (upd_en) ghr_d = {ghr_q[HIST_W-2:0], bp.update_taken};
  end

  // GHR register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end

  assign q_idx = bp.query_pc[IDX_W+1:2]  ^ IDX_W'(ghr_q);
  assign u_idx = bp.update_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
`else
  assign q_idx = bp.query_pc[IDX_W+1:2];
  assign u_idx = bp.update_pc[IDX_W+1:2];
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.query_pc[1:0], bp.update_pc[1:0],
                            bp.update_pc[31:IDX_W+2]};

  bht_table #(.IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (q_idx),
    .rd_ctr   (q_ctr),
    .we       (upd_en),
    .wr_idx   (u_idx),
    .wr_taken (bp.update_taken)
  );

  // Opcode decode and target computation (wraps mod 2^32)
  always_comb begin
    dec.valid   = 1'b1;
    dec.is_jump = 1'b0;
    dec.taken   = 1'b0;
    dec.target  = bp.query_pc + 32'd4;
    case (bp.query_instr[6:0])
      OP_JAL: begin
        dec.is_jump = 1'b1;
        dec.taken   = 1'b1;
        dec.target  = bp.query_pc + j_imm(bp.query_instr);
      end
      OP_BRANCH: begin
        dec.is_jump = 1'b1;
        dec.taken   = q_ctr[1];
        if (q_ctr[1]) dec.target = bp.query_pc + b_imm(bp.query_instr);
      end
      default: ;
    endcase
  end

  // Output capture: pulse valid per accepted query, flush drops it, rdy freezes
  always_comb begin
    pred_d = pred_q;
    if (rdy) begin
      pred_d.valid = 1'b0;
      if (bp.query_valid && !bp.jump_wrong) pred_d = dec;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pred_q <= '0;
    else      pred_q <= pred_d;
  end

  assign bp.pred_valid   = pred_q.valid;
  assign bp.pred_is_jump = pred_q.is_jump;
  assign bp.pred_taken   = pred_q.taken;
  assign bp.pred_target  = pred_q.target;
endmodule
